// File: rtl/addatone_pkg.sv
// Shared definitions for the addatone SPI blocks: FSM state encodings,
// synchroniser depth and default word width.
package addatone_pkg;

    typedef enum logic [1:0] {
        sm_idle  = 2'd0,
        sm_load  = 2'd1,
        sm_shift = 2'd2,
        sm_done  = 2'd3
    } spi_state_t;

    localparam int SPI_SYNC_STAGES   = 2;
    localparam int DEFAULT_WORD_BITS = 16;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, with registered
// one-cycle rise and fall pulses taken from the synchronised level.
module spi_sync_edge
    import addatone_pkg::*;
#(
    parameter int STAGES = SPI_SYNC_STAGES
) (
    input  logic clock,
    input  logic reset,
    input  logic async_level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Synchroniser chain plus registered edge detection. Clearing to 0 means a
    // line that is high after reset shows a rise, and a low one shows nothing.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_r <= '0;
            prev_r <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], async_level};
            prev_r <= sync_r[STAGES-1];
            rise   <= sync_r[STAGES-1] & ~prev_r;
            fall   <= ~sync_r[STAGES-1] & prev_r;
        end
    end

endmodule

// File: rtl/spi_status_out.sv
// SPI-slave (mode 0) status transmitter on MISO, oversampling CS/SCK in the
// Main_Clock domain. Define STATUS_CHECKSUM_EN to append a sum word to each frame.
module spi_status_out
    import addatone_pkg::*;
#(
    parameter int NUM_WORDS = 3,
    parameter int WORD_BITS = DEFAULT_WORD_BITS
) (
    input  logic                           i_Clock,
    input  logic                           i_Reset,
    input  logic                           i_SPI_CS,
    input  logic                           i_SPI_Clock,
    input  logic [NUM_WORDS*WORD_BITS-1:0] i_Data,
    output logic                           o_SPI_Data,
    output logic                           o_Data_Sent,
    output logic                           o_Frame_Error,
    output logic                           o_Busy
);

    localparam int DATA_BITS = NUM_WORDS * WORD_BITS;
`ifdef STATUS_CHECKSUM_EN
    localparam int FRAME_BITS = DATA_BITS + WORD_BITS;
`else
    localparam int FRAME_BITS = DATA_BITS;
`endif
    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    logic                  cs_rise_s;
    logic                  cs_fall_s;
    logic                  sck_rise_s;
    logic                  sck_fall_s;
    logic [FRAME_BITS-1:0] snap_s;
    logic [FRAME_BITS-1:0] shift_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  cs_seen_high_r;
    spi_state_t            state_r;

    spi_sync_edge u_cs_sync (
        .clock       (i_Clock),
        .reset       (i_Reset),
        .async_level (i_SPI_CS),
        .rise        (cs_rise_s),
        .fall        (cs_fall_s)
    );

    spi_sync_edge u_sck_sync (
        .clock       (i_Clock),
        .reset       (i_Reset),
        .async_level (i_SPI_Clock),
        .rise        (sck_rise_s),
        .fall        (sck_fall_s)
    );

    // Reorder the packed inputs so word 0 sits at the buffer MSB end.
    always_comb begin
        snap_s = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            snap_s[FRAME_BITS-1-k*WORD_BITS -: WORD_BITS] = i_Data[k*WORD_BITS +: WORD_BITS];
        end
    end

`ifdef STATUS_CHECKSUM_EN
    logic [WORD_BITS-1:0] sum_s;

    // Modular sum of the snapshotted words held in the shift buffer.
    always_comb begin
        sum_s = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            sum_s = sum_s + shift_r[FRAME_BITS-1-k*WORD_BITS -: WORD_BITS];
        end
    end
`endif

    // Frame state machine. The snapshot is taken on the edge that leaves idle so
    // the first MSB is on MISO during the load cycle; load then resets the count.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_r        <= sm_idle;
            shift_r        <= '0;
            cnt_r          <= '0;
            cs_seen_high_r <= 1'b0;
            o_SPI_Data     <= 1'b0;
            o_Data_Sent    <= 1'b0;
            o_Frame_Error  <= 1'b0;
            o_Busy         <= 1'b0;
        end else begin
            if (cs_rise_s) begin
                cs_seen_high_r <= 1'b1;
            end
            case (state_r)
                sm_idle: begin
                    o_SPI_Data    <= 1'b0;
                    o_Data_Sent   <= 1'b0;
                    o_Frame_Error <= 1'b0;
                    if (cs_fall_s && cs_seen_high_r) begin
                        state_r    <= sm_load;
                        shift_r    <= snap_s;
                        o_SPI_Data <= snap_s[FRAME_BITS-1];
                        cnt_r      <= '0;
                        o_Busy     <= 1'b1;
                    end
                end
                sm_load: begin
                    cnt_r <= '0;
`ifdef STATUS_CHECKSUM_EN
                    shift_r[WORD_BITS-1:0] <= sum_s;
`endif
                    if (cs_rise_s) begin
                        state_r       <= sm_done;
                        o_SPI_Data    <= 1'b0;
                        o_Frame_Error <= 1'b1;
                    end else begin
                        state_r <= sm_shift;
                    end
                end
                sm_shift: begin
                    // A CS release outranks any SCK edge landing in the same cycle.
                    if (cs_rise_s) begin
                        state_r       <= sm_done;
                        o_SPI_Data    <= 1'b0;
                        o_Data_Sent   <= (cnt_r == CNT_FULL);
                        o_Frame_Error <= (cnt_r != CNT_FULL);
                    end else if (sck_rise_s) begin
                        if (cnt_r != CNT_SAT) begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end else if (sck_fall_s) begin
                        shift_r    <= {shift_r[FRAME_BITS-2:0], 1'b0};
                        o_SPI_Data <= shift_r[FRAME_BITS-2];
                    end
                end
                sm_done: begin
                    o_Data_Sent   <= 1'b0;
                    o_Frame_Error <= 1'b0;
                    o_Busy        <= 1'b0;
                    state_r       <= sm_idle;
                end
                default: begin
                    state_r       <= sm_idle;
                    o_SPI_Data    <= 1'b0;
                    o_Data_Sent   <= 1'b0;
                    o_Frame_Error <= 1'b0;
                    o_Busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
